hw_frame_mailbox: RTL and testbench
===================================

Name: hw_frame_mailbox

Overview:
- Consumes the ten 32-bit software-to-hardware PIO words and the 2-bit to_hw_sig/to_sw_sig handshake from the Nios system.
- Implements a 4-phase request/acknowledge protocol that captures all ten words atomically into a staging buffer.
- Commits the staging buffer to a frame-stable shadow copy only on a frame_sync pulse, so the game/render logic never sees a half-updated word set mid-frame.
- Also carries a software "game reset" request and keeps drop and error status.

Parameters:
NUM_PORTS, 10, number of 32-bit words captured per transfer
DATA_W, 32, width of each word
TIMEOUT_CYCLES, 1000000, ack cycles before software is deemed stuck

Ports:
Clk  in  1  system clock, shared with the Nios system
Reset  in  1  asynchronous, active-high reset
port_data_in  in  NUM_PORTS*DATA_W  to_hw_port0..9 concatenated; port0 in bits [31:0]
to_hw_sig  in  2  software request: 00 idle, 01 data ready, 10 game reset, 11 reserved
frame_sync  in  1  one-cycle pulse at vertical blank
to_sw_sig  out  2  hardware ack: 00 idle, 01 data ack, 10 reset ack
frame_data  out  NUM_PORTS*DATA_W  committed, frame-stable word set
frame_valid  out  1  one-cycle pulse when frame_data updates
game_reset  out  1  one-cycle pulse on accepted reset request
drop_count  out  8  saturating count of staged sets overwritten before commit
timeout_err  out  1  sticky: an ack phase exceeded TIMEOUT_CYCLES

Behaviour:
- Reset (async, active-high) values:
  - to_sw_sig=00, frame_data=0, frame_valid=0, game_reset=0, drop_count=0, timeout_err=0.
  - Staging buffer=0, pending=0, state=IDLE, sig_q=00, timeout counter=0.
- to_hw_sig is registered once (sig_q). The FSM acts on sig_q only.
- to_sw_sig is decoded from the state register: IDLE→00, DATA_ACK→01, RST_ACK→10.
- FSM in IDLE:
  - sig_q==01: load staging from port_data_in on this edge; if pending already 1, drop_count+=1 (saturates at 255); set pending=1; go DATA_ACK.
  - sig_q==10: pulse game_reset next cycle; clear pending and staging; go RST_ACK.
  - sig_q==11 or 00: stay in IDLE; 11 is ignored.
- DATA_ACK / RST_ACK:
  - Hold until sig_q==00, then go IDLE.
  - A new request is accepted only after sig_q has returned to 00 and the FSM is back in IDLE. No re-capture while the request level stays high.
- Latency: to_hw_sig change at edge N; sig_q at edge N+1; state and staging update at edge N+2; to_sw_sig valid after N+2. Release follows the same 2-cycle path back to 00.
- Commit on frame_sync:
  - If pending==1, frame_data<=staging, frame_valid pulses 1 cycle, pending<=0.
  - If pending==0, nothing happens and frame_valid stays 0.
- Capture and frame_sync in the same cycle:
  - The commit uses the staging value from before the capture.
  - The new capture sets pending=1; pending is not cleared.
  - drop_count does not increment, because the old set was committed.
- Reset request and frame_sync in the same cycle: the reset wins. No commit, pending=0.
- frame_data is never cleared by a game reset, only by Reset.
- Timeout counter:
  - Counts cycles in DATA_ACK/RST_ACK and clears in IDLE.
  - On reaching TIMEOUT_CYCLES-1, timeout_err is set and the FSM stays put; the counter holds.
  - timeout_err clears only on Reset or on completion of a game reset handshake (RST_ACK→IDLE).
- Asserting Reset mid-handshake forces IDLE and to_sw_sig=00 immediately. Software must drop its request and restart.

Test Plan:
- Data transfer: Reset, write word i=0x1000+i, to_hw_sig=01.
  - Expect to_sw_sig=01 two cycles later; release to 00, then to_sw_sig=00 two cycles later.
  - frame_sync pulse → frame_valid for 1 cycle; frame_data word9=0x1009; frame_data unchanged before frame_sync.
- Drop counting: two full transfers (0xA.., then 0xB..) with no frame_sync.
  - Expect drop_count=1.
  - Next frame_sync commits the 0xB.. set; a second frame_sync gives no frame_valid.
- Simultaneous capture/commit: pending set A, new request so the capture edge coincides with frame_sync.
  - Expect frame_data=A, pending=1, drop_count unchanged; next frame_sync gives B.
- Game reset: pending set staged, to_hw_sig=10.
  - Expect one game_reset pulse, to_sw_sig=10, pending cleared; next frame_sync gives no frame_valid.
  - Prior frame_data is retained.
- Timeout: TIMEOUT_CYCLES=16, hold to_hw_sig=01.
  - Expect timeout_err=1 after 16 ack cycles, to_sw_sig still 01.
  - Full reset handshake clears timeout_err; to_hw_sig=11 for 20 cycles → to_sw_sig stays 00.
- Reset mid-operation: assert Reset while in DATA_ACK.
  - Expect to_sw_sig=00 with no clock edge, all outputs at reset values, and a fresh transfer afterwards works.

Source files
------------

// File: rtl/hw_frame_mailbox_if.sv
// ============================================================================
// Module      : hw_frame_mailbox_if
// Description : Software-to-hardware PIO word set, handshake and frame outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hw_frame_mailbox_if #(
  parameter int NUM_PORTS = 10,
  parameter int DATA_W    = 32
);
  logic [NUM_PORTS*DATA_W-1:0] port_data_in;
  logic [1:0]                  to_hw_sig;
  logic                        frame_sync;
  logic [1:0]                  to_sw_sig;
  logic [NUM_PORTS*DATA_W-1:0] frame_data;
  logic                        frame_valid;
  logic                        game_reset;
  logic [7:0]                  drop_count;
  logic                        timeout_err;

  modport master (
    output port_data_in, to_hw_sig, frame_sync,
    input  to_sw_sig, frame_data, frame_valid, game_reset, drop_count, timeout_err
  );

  modport slave (
    input  port_data_in, to_hw_sig, frame_sync,
    output to_sw_sig, frame_data, frame_valid, game_reset, drop_count, timeout_err
  );
endinterface

`default_nettype wire

// File: rtl/hw_frame_mailbox.sv
// ============================================================================
// Module      : hw_frame_mailbox
// Description : 4-phase PIO mailbox with staging buffer and frame-synchronous commit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hw_frame_mailbox #(
  parameter int NUM_PORTS      = 10,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              Clk,
  input  logic              Reset,
  hw_frame_mailbox_if.slave bus
);

  localparam int                 C_WORDS_W  = NUM_PORTS * DATA_W;
  localparam int                 C_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DATA_ACK = 2'd1,
    S_RST_ACK  = 2'd2
  } state_t;

  state_t               r_state;
  logic [1:0]           r_sig_q;
  logic [C_WORDS_W-1:0] r_staging;
  logic [C_WORDS_W-1:0] r_frame_data;
  logic                 r_pending;
  logic                 r_frame_valid;
  logic                 r_game_reset;
  logic                 r_timeout_err;
  logic [7:0]           r_drop_count;
  logic [C_CNT_W-1:0]   r_tmo_cnt;

  logic                 w_capture;
  logic                 w_rst_req;
  logic                 w_commit;
  logic [1:0]           w_to_sw_sig;

  assign w_capture = (r_state == S_IDLE) && (r_sig_q == 2'b01);
  assign w_rst_req = (r_state == S_IDLE) && (r_sig_q == 2'b10);
  // A reset request discards the staged set, so it suppresses a coincident commit.
  assign w_commit  = bus.frame_sync && r_pending && !w_rst_req;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_sig_q       <= 2'b00;
      r_staging     <= '0;
      r_frame_data  <= '0;
      r_pending     <= 1'b0;
      r_frame_valid <= 1'b0;
      r_game_reset  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_drop_count  <= 8'd0;
      r_tmo_cnt     <= '0;
    end else begin
      r_sig_q       <= bus.to_hw_sig;
      r_frame_valid <= 1'b0;
      r_game_reset  <= 1'b0;

      if (w_commit) begin
        r_frame_data  <= r_staging;
        r_frame_valid <= 1'b1;
        r_pending     <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_tmo_cnt <= '0;
          if (w_capture) begin
            r_staging <= bus.port_data_in;
            r_pending <= 1'b1;
            // Only an uncommitted set is lost; a same-cycle commit already took it.
            if (r_pending && !w_commit && (r_drop_count != 8'hFF))
              r_drop_count <= r_drop_count + 8'd1;
            r_state <= S_DATA_ACK;
          end else if (w_rst_req) begin
            r_game_reset <= 1'b1;
            r_pending    <= 1'b0;
            r_staging    <= '0;
            r_state      <= S_RST_ACK;
          end
        end
        S_DATA_ACK, S_RST_ACK: begin
          if (r_sig_q == 2'b00) begin
            if (r_state == S_RST_ACK)
              r_timeout_err <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_tmo_cnt == C_CNT_LAST) begin
            r_timeout_err <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + C_CNT_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_to_sw_sig = 2'b00;
    case (r_state)
      S_DATA_ACK: w_to_sw_sig = 2'b01;
      S_RST_ACK:  w_to_sw_sig = 2'b10;
      default:    w_to_sw_sig = 2'b00;
    endcase
  end

  assign bus.to_sw_sig   = w_to_sw_sig;
  assign bus.frame_data  = r_frame_data;
  assign bus.frame_valid = r_frame_valid;
  assign bus.game_reset  = r_game_reset;
  assign bus.drop_count  = r_drop_count;
  assign bus.timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_hw_frame_mailbox.sv
// ============================================================================
// Module      : tb_hw_frame_mailbox
// Description : Table vectors, directed sequences and random traffic vs. a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hw_frame_mailbox;

  localparam int NP  = 10;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hw_frame_mailbox_if #(.NUM_PORTS(NP), .DATA_W(DW)) bus ();

  hw_frame_mailbox #(.NUM_PORTS(NP), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: the mailbox as software sees it
  logic [DW-1:0] m_stage [NP];
  logic [DW-1:0] m_frame [NP];
  logic          m_pending;
  logic [1:0]    m_sigq;
  logic [1:0]    m_ack;
  int            m_ack_cycles;
  int            m_drop;
  logic          m_err, m_fv, m_gr;

  typedef struct {
    logic [1:0]    sig;
    logic          fs;
    logic [1:0]    ack;
    logic          fv;
    logic [DW-1:0] w9;
  } vec_t;

  task automatic chk(string name, logic [NP*DW-1:0] act, logic [NP*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [NP*DW-1:0] m_frame_packed();
    logic [NP*DW-1:0] v;
    for (int i = 0; i < NP; i++) v[i*DW +: DW] = m_frame[i];
    return v;
  endfunction

  function automatic logic [DW-1:0] word9();
    logic [NP*DW-1:0] v;
    v = bus.frame_data;
    return v[9*DW +: DW];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_stage[i] = '0;
      m_frame[i] = '0;
    end
    m_pending = 0; m_sigq = 0; m_ack = 0; m_ack_cycles = 0;
    m_drop = 0; m_err = 0; m_fv = 0; m_gr = 0;
  endtask

  // Applies one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    logic [1:0] prev;
    logic       pend0, rreq, commit;
    prev  = m_ack;
    pend0 = m_pending;
    m_fv  = 0;
    m_gr  = 0;
    rreq   = (prev == 2'b00) && (m_sigq == 2'b10);
    commit = bus.frame_sync && pend0 && !rreq;
    if (commit) begin
      for (int i = 0; i < NP; i++) m_frame[i] = m_stage[i];
      m_fv = 1;
      m_pending = 0;
    end
    if (prev == 2'b00) begin
      m_ack_cycles = 0;
      if (m_sigq == 2'b01) begin
        if (pend0 && !commit && m_drop < 255) m_drop++;
        for (int i = 0; i < NP; i++) m_stage[i] = bus.port_data_in[i*DW +: DW];
        m_pending = 1;
        m_ack = 2'b01;
      end else if (rreq) begin
        for (int i = 0; i < NP; i++) m_stage[i] = '0;
        m_pending = 0;
        m_gr = 1;
        m_ack = 2'b10;
      end
    end else begin
      if (m_sigq == 2'b00) begin
        if (prev == 2'b10) m_err = 0;
        m_ack = 2'b00;
      end else if (m_ack_cycles == TMO - 1) begin
        m_err = 1;
      end else begin
        m_ack_cycles++;
      end
    end
    m_sigq = bus.to_hw_sig;
  endtask

  task automatic compare_all(string tag);
    chk({tag, ".to_sw_sig"},   NP*DW'(bus.to_sw_sig),   NP*DW'(m_ack));
    chk({tag, ".frame_valid"}, NP*DW'(bus.frame_valid), NP*DW'(m_fv));
    chk({tag, ".game_reset"},  NP*DW'(bus.game_reset),  NP*DW'(m_gr));
    chk({tag, ".drop_count"},  NP*DW'(bus.drop_count),  NP*DW'(m_drop));
    chk({tag, ".timeout_err"}, NP*DW'(bus.timeout_err), NP*DW'(m_err));
    chk({tag, ".frame_data"},  bus.frame_data,          m_frame_packed());
  endtask

  task automatic cycle(string tag);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic set_data(logic [DW-1:0] base);
    for (int i = 0; i < NP; i++) bus.port_data_in[i*DW +: DW] = base + DW'(i);
  endtask

  task automatic transfer(logic [DW-1:0] base, string tag);
    set_data(base);
    bus.to_hw_sig = 2'b01;
    cycle(tag); cycle(tag);
    bus.to_hw_sig = 2'b00;
    cycle(tag); cycle(tag);
  endtask

  task automatic pulse_fs(string tag);
    bus.frame_sync = 1'b1;
    cycle(tag);
    bus.frame_sync = 1'b0;
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{sig: 2'b01, fs: 1'b0, ack: 2'b00, fv: 1'b0, w9: 32'h0};
    vecs[1] = '{sig: 2'b01, fs: 1'b0, ack: 2'b01, fv: 1'b0, w9: 32'h0};
    vecs[2] = '{sig: 2'b00, fs: 1'b0, ack: 2'b01, fv: 1'b0, w9: 32'h0};
    vecs[3] = '{sig: 2'b00, fs: 1'b0, ack: 2'b00, fv: 1'b0, w9: 32'h0};
    vecs[4] = '{sig: 2'b00, fs: 1'b1, ack: 2'b00, fv: 1'b1, w9: 32'h1009};
    vecs[5] = '{sig: 2'b00, fs: 1'b0, ack: 2'b00, fv: 1'b0, w9: 32'h1009};

    rst = 1'b1;
    bus.port_data_in = '0;
    bus.to_hw_sig    = 2'b00;
    bus.frame_sync   = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    compare_all("reset");
    rst = 1'b0;

    // Basic transfer, table driven
    set_data(32'h1000);
    for (int v = 0; v < 6; v++) begin
      bus.to_hw_sig  = vecs[v].sig;
      bus.frame_sync = vecs[v].fs;
      cycle("xfer");
      chk($sformatf("vec%0d.ack", v), NP*DW'(bus.to_sw_sig),   NP*DW'(vecs[v].ack));
      chk($sformatf("vec%0d.fv", v),  NP*DW'(bus.frame_valid), NP*DW'(vecs[v].fv));
      chk($sformatf("vec%0d.w9", v),  NP*DW'(word9()),         NP*DW'(vecs[v].w9));
    end
    bus.frame_sync = 1'b0;

    // Drop counting
    transfer(32'hA000, "dropA");
    transfer(32'hB000, "dropB");
    chk("drop.count", NP*DW'(bus.drop_count), NP*DW'(1));
    chk("drop.w9_held", NP*DW'(word9()), NP*DW'(32'h1009));
    pulse_fs("drop.fs1");
    chk("drop.fv1", NP*DW'(bus.frame_valid), NP*DW'(1));
    chk("drop.w9", NP*DW'(word9()), NP*DW'(32'hB009));
    pulse_fs("drop.fs2");
    chk("drop.fv2", NP*DW'(bus.frame_valid), NP*DW'(0));

    // Capture edge coincides with frame_sync
    transfer(32'hC000, "simA");
    set_data(32'hD000);
    bus.to_hw_sig = 2'b01;
    cycle("simB");
    bus.frame_sync = 1'b1;
    cycle("simB");
    bus.frame_sync = 1'b0;
    chk("sim.w9A", NP*DW'(word9()), NP*DW'(32'hC009));
    chk("sim.fv", NP*DW'(bus.frame_valid), NP*DW'(1));
    chk("sim.drop", NP*DW'(bus.drop_count), NP*DW'(1));
    bus.to_hw_sig = 2'b00;
    cycle("simB"); cycle("simB");
    pulse_fs("sim.fs");
    chk("sim.w9B", NP*DW'(word9()), NP*DW'(32'hD009));

    // Game reset with a pending set
    transfer(32'hE000, "grst");
    bus.to_hw_sig = 2'b10;
    cycle("grst");
    bus.frame_sync = 1'b1;
    cycle("grst");
    bus.frame_sync = 1'b0;
    chk("grst.ack", NP*DW'(bus.to_sw_sig), NP*DW'(2'b10));
    chk("grst.pulse", NP*DW'(bus.game_reset), NP*DW'(1));
    chk("grst.nocommit", NP*DW'(bus.frame_valid), NP*DW'(0));
    cycle("grst");
    chk("grst.pulse_end", NP*DW'(bus.game_reset), NP*DW'(0));
    bus.to_hw_sig = 2'b00;
    cycle("grst"); cycle("grst");
    pulse_fs("grst.fs");
    chk("grst.fv", NP*DW'(bus.frame_valid), NP*DW'(0));
    chk("grst.w9_kept", NP*DW'(word9()), NP*DW'(32'hD009));

    // Timeout while request is held
    set_data(32'hF000);
    bus.to_hw_sig = 2'b01;
    cycle("tmo"); cycle("tmo");
    for (int k = 0; k < TMO - 1; k++) cycle("tmo");
    chk("tmo.before", NP*DW'(bus.timeout_err), NP*DW'(0));
    cycle("tmo");
    chk("tmo.err", NP*DW'(bus.timeout_err), NP*DW'(1));
    chk("tmo.ack", NP*DW'(bus.to_sw_sig), NP*DW'(2'b01));
    bus.to_hw_sig = 2'b00;
    cycle("tmo"); cycle("tmo");
    chk("tmo.sticky", NP*DW'(bus.timeout_err), NP*DW'(1));
    bus.to_hw_sig = 2'b10;
    cycle("tmo"); cycle("tmo");
    bus.to_hw_sig = 2'b00;
    cycle("tmo"); cycle("tmo");
    chk("tmo.cleared", NP*DW'(bus.timeout_err), NP*DW'(0));
    bus.to_hw_sig = 2'b11;
    for (int k = 0; k < 20; k++) begin
      cycle("rsvd");
      chk("rsvd.ack", NP*DW'(bus.to_sw_sig), NP*DW'(2'b00));
    end
    bus.to_hw_sig = 2'b00;
    cycle("rsvd");

    // Asynchronous reset during DATA_ACK
    set_data(32'h2000);
    bus.to_hw_sig = 2'b01;
    cycle("arst"); cycle("arst");
    chk("arst.pre", NP*DW'(bus.to_sw_sig), NP*DW'(2'b01));
    bus.to_hw_sig = 2'b00;
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all("arst.async");
    @(negedge clk);
    rst = 1'b0;
    transfer(32'h3000, "arst.fresh");
    pulse_fs("arst.fs");
    chk("arst.w9", NP*DW'(word9()), NP*DW'(32'h3009));

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 4) == 0) bus.to_hw_sig = 2'($urandom_range(0, 3));
      bus.frame_sync = ($urandom_range(0, 6) == 0);
      for (int i = 0; i < NP; i++) bus.port_data_in[i*DW +: DW] = $urandom;
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
